store_merge_ctrl: RTL and testbench
===================================

Name: store_merge_ctrl

Overview:
Sequences the read-modify-write needed for sub-doubleword stores (SW/SH/SB) on the 64-bit data memory. It accepts one store request, reads the target doubleword, merges the new low-order bytes into it, writes the result back, then signals completion. SD bypasses the read. It sits between the core's store issue logic and the data memory port.

Parameters:
ADDR_W, 64, memory address width
MEM_RD_LAT, 1, cycles from mem_rd_en high to mem_rdata valid; legal values are 1 to 7.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  store request present
req_ready  out  1  high only in IDLE
req_type  in  4  0=SW, 1=SH, 2=SB, 3=SD, any other value is illegal
req_addr  in  ADDR_W  doubleword address, used unmodified
req_data  in  64  store source register value
mem_addr  out  ADDR_W  memory address
mem_rd_en  out  1  one-cycle read strobe
mem_rdata  in  64  read data
mem_wr_en  out  1  one-cycle write strobe
mem_wdata  out  64  merged write data
bypass_flush  in  1  invalidates the bypass entry; ignored without the feature
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse, coincident with done, for an illegal type

Behaviour:
- Reset values while reset is low: state=IDLE, req_ready=1, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, done=0, err=0, busy=0, wait counter=0.
- Reset mid-operation: abort immediately with no write issued. Late mem_rdata is ignored.
- States: IDLE, READ, WAIT, WRITE, DONE.
- Accept: a request is accepted when req_valid && req_ready in IDLE. On accept, latch type, address and data.
- Next state after accept:
  - SW, SH or SB go to READ.
  - SD goes to WRITE with mem_wdata=req_data.
  - An illegal type goes to DONE with err set.
- READ lasts one cycle: mem_rd_en=1, mem_addr=latched address. Next state is WAIT.
- WAIT lasts exactly MEM_RD_LAT cycles, counted by the wait counter. In the last WAIT cycle, capture the merged data, with M = mem_rdata and D = latched data:
  - SW: {M[63:32], D[31:0]}
  - SH: {M[63:16], D[15:0]}
  - SB: {M[63:8], D[7:0]}
- WRITE lasts one cycle: mem_wr_en=1, mem_addr=latched address, mem_wdata=merged value. Next state is DONE.
- DONE lasts one cycle: done=1 (and err=1 for an illegal type), then return to IDLE.
- mem_addr and mem_wdata hold their last values outside the strobe cycles.
- Latency, with the accept edge at cycle 0:
  - SW/SH/SB: mem_rd_en at cycle 1, write at cycle 2+MEM_RD_LAT, done at cycle 3+MEM_RD_LAT.
  - SD: write at cycle 1, done at cycle 2.
  - Illegal type: done+err at cycle 1.
- Back-to-back requests: req_ready returns high the cycle after DONE. Throughput is one store per 4+MEM_RD_LAT cycles for SW/SH/SB.
- Requests presented while req_ready=0 are not latched. The requester holds req_valid until accepted.
- mem_rd_en and mem_wr_en are never high in the same cycle.

Optional Feature:
STORE_MERGE_BYPASS_EN
- Defined:
  - Keep one entry {valid, addr, data} holding the last doubleword written.
  - A SW/SH/SB whose address equals a valid entry skips READ and WAIT. It merges against the entry data and goes directly to WRITE at cycle 1, with done at cycle 2.
  - Every WRITE, including SD, loads the entry with valid=1.
  - bypass_flush=1 clears valid on the next edge; flush wins over a simultaneous WRITE load. Reset clears valid.
- Undefined: no entry is built, bypass_flush is ignored, and every SW/SH/SB performs the full read.

Test Plan:
- SW, MEM_RD_LAT=1, memory=0xAAAA_BBBB_CCCC_DDDD, req_data=0x1111_2222_3333_4444 -> rd_en at cycle 1, wr_en at cycle 3 with wdata=0xAAAA_BBBB_3333_4444, done at cycle 4.
- SH then SB to the same address, memory=0xFFFF_FFFF_FFFF_FFFF, data=0x0123_4567_89AB_CDEF -> SH writes 0xFFFF_FFFF_FFFF_CDEF; SB writes 0xFFFF_FFFF_FFFF_FFEF when bypass is undefined and memory was reset to all ones between the two stores.
- SD, data=0xDEAD_BEEF_0000_0001 -> no rd_en, wr_en at cycle 1 with that data, done at cycle 2.
- req_type=5 -> no memory strobes, done=err=1 at cycle 1, req_ready=1 at cycle 2.
- MEM_RD_LAT=3 SB with reset driven low at cycle 3 -> all outputs return to their reset values immediately, no wr_en ever asserted, a new request is accepted after release.
- Bypass defined: SD to 0x40, then SW to 0x40 -> SW has no rd_en, wr_en at cycle 1. Repeat with bypass_flush pulsed between the two -> the full read occurs.

Source files
------------

// File: rtl/store_merge_ctrl.sv
// -----------------------------------------------------------------------------
// store_merge_ctrl
//
// Read-modify-write sequencer for sub-doubleword stores (SW/SH/SB) on a 64-bit
// data memory. A store reads the target doubleword, replaces its low-order
// bytes with the store data and writes the merged value back. SD skips the
// read, and an illegal store type finishes at once with an error pulse.
//
// Optional feature macro: STORE_MERGE_BYPASS_EN
//   When defined, a one-entry buffer keeps the last doubleword written. A
//   SW/SH/SB to that address merges against the buffered copy and skips the
//   memory read. bypass_flush invalidates the entry. When the macro is not
//   defined there is no entry, bypass_flush is ignored, and every SW/SH/SB
//   reads memory.
// -----------------------------------------------------------------------------
module store_merge_ctrl #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned MEM_RD_LAT = 1    // legal range 1..7
) (
  input  logic              clk,
  input  logic              reset,         // asynchronous, active-low

  // store request from the issue logic
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_data,

  // data memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [63:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [63:0]       mem_wdata,

  // bypass control and status
  input  logic              bypass_flush,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [3:0] T_SW = 4'd0;
  localparam logic [3:0] T_SH = 4'd1;
  localparam logic [3:0] T_SB = 4'd2;
  localparam logic [3:0] T_SD = 4'd3;

  // Three bits cover the full 1..7 latency range.
  localparam int unsigned      CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LAT - 1);

  // Byte lanes supplied by the store data; the rest come from the old value.
  function automatic logic [7:0] byte_en(input logic [3:0] t);
    logic [7:0] be;
    case (t)
      T_SW:    be = 8'h0F;
      T_SH:    be = 8'h03;
      T_SB:    be = 8'h01;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  // Lane-by-lane merge of new store data over the old doubleword.
  function automatic logic [63:0] merge_bytes(input logic [7:0]  be,
                                              input logic [63:0] old_dw,
                                              input logic [63:0] new_dw);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = be[b] ? new_dw[8*b +: 8] : old_dw[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic is_partial(input logic [3:0] t);
    return (t == T_SW) || (t == T_SH) || (t == T_SB);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        type_q;
  logic [63:0]       data_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              mem_rd_en_q;
  logic              mem_wr_en_q;
  // mem_addr_q also serves as the latched request address: it is loaded at
  // accept for every request that touches memory and held until the next one.
  logic [ADDR_W-1:0] mem_addr_q;
  logic [63:0]       mem_wdata_q;

  // Bypass lookup results consumed by the FSM.
  logic              byp_hit;
  logic [63:0]       byp_data;

`ifdef STORE_MERGE_BYPASS_EN
  logic              byp_valid_q;
  logic [ADDR_W-1:0] byp_addr_q;
  logic [63:0]       byp_data_q;

  assign byp_hit  = byp_valid_q && (byp_addr_q == req_addr);
  assign byp_data = byp_data_q;

  // Entry valid: set by every write, cleared by flush (flush wins) or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byp_valid_q <= 1'b0;
    end else if (bypass_flush) begin
      byp_valid_q <= 1'b0;
    end else if (state_q == S_WRITE) begin
      byp_valid_q <= 1'b1;
    end
  end

  // Entry payload: captures the address and data of every write.
  // NOTE: payload registers carry no reset; they are only consulted while
  // byp_valid_q is set, and that flag is what reset clears.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE) begin
      byp_addr_q <= mem_addr_q;
      byp_data_q <= mem_wdata_q;
    end
  end
`else
  logic unused_bypass_flush;

  assign unused_bypass_flush = bypass_flush;
  assign byp_hit             = 1'b0;
  assign byp_data            = '0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer: state, wait counter, latched request and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register here is assigned with <= so all of them see the
  // pre-edge values of each other, exactly like the flops they become.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      type_q      <= '0;
      data_q      <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Strobes and status pulses last a single cycle unless re-armed below.
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            type_q      <= req_type;
            data_q      <= req_data;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_type == T_SD) begin
              // Full doubleword: nothing to merge, write straight away.
              state_q     <= S_WRITE;
              mem_wr_en_q <= 1'b1;
              mem_addr_q  <= req_addr;
              mem_wdata_q <= req_data;
            end else if (is_partial(req_type)) begin
              mem_addr_q <= req_addr;
              if (byp_hit) begin
                // Buffered copy of this doubleword replaces the memory read.
                state_q     <= S_WRITE;
                mem_wr_en_q <= 1'b1;
                mem_wdata_q <= merge_bytes(byte_en(req_type), byp_data,
                                           req_data);
              end else begin
                state_q     <= S_READ;
                mem_rd_en_q <= 1'b1;
              end
            end else begin
              // Illegal type: report immediately, memory untouched.
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end

        S_READ: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end

        S_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            // Read data is valid in this cycle only: merge and write next.
            state_q     <= S_WRITE;
            cnt_q       <= '0;
            mem_wr_en_q <= 1'b1;
            mem_wdata_q <= merge_bytes(byte_en(type_q), mem_rdata, data_q);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_WRITE: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end

        S_DONE: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end

        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_merge_ctrl.sv
// -----------------------------------------------------------------------------
// tb_store_merge_ctrl
//
// Self-checking bench for store_merge_ctrl with a read latency of 3. A simple
// memory with a fixed-latency read pipe sits on the memory port; a reference
// model (shadow memory plus a last-write entry when STORE_MERGE_BYPASS_EN is
// defined) predicts strobe timing, addresses and merged write data.
// -----------------------------------------------------------------------------
module tb_store_merge_ctrl;

  localparam int unsigned AW  = 64;
  localparam int unsigned LAT = 3;

`ifdef STORE_MERGE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_type;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [63:0]   mem_rdata;
  logic          mem_wr_en;
  logic [63:0]   mem_wdata;
  logic          bypass_flush;
  logic          busy;
  logic          done;
  logic          err;

  store_merge_ctrl #(.ADDR_W(AW), .MEM_RD_LAT(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_type     (req_type),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rdata    (mem_rdata),
    .mem_wr_en    (mem_wr_en),
    .mem_wdata    (mem_wdata),
    .bypass_flush (bypass_flush),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory environment: writes land on the edge, reads return LAT cycles after
  // the strobe cycle; outside that window the read bus carries random junk.
  // ---------------------------------------------------------------------------
  bit   [63:0] tb_mem [bit [63:0]];
  logic        pipe_v [LAT];
  logic [63:0] pipe_d [LAT];
  logic [63:0] junk_q;

  function automatic logic [63:0] tb_mem_rd(input logic [63:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : 64'h0;
  endfunction

  always @(posedge clk) begin
    if (mem_wr_en) tb_mem[mem_addr] = mem_wdata;
    pipe_v[0] <= mem_rd_en;
    pipe_d[0] <= tb_mem_rd(mem_addr);
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    junk_q <= {$urandom, $urandom};
  end

  assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk_q;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit [63:0] mdl_mem [bit [63:0]];
  bit        e_v;
  bit [63:0] e_a;
  bit [63:0] e_d;

  function automatic logic [63:0] mdl_rd(input logic [63:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : 64'h0;
  endfunction

  task automatic poke(input logic [63:0] a, input logic [63:0] v);
    tb_mem[a]  = v;
    mdl_mem[a] = v;
  endtask

  task automatic flush_pulse();
    bypass_flush = 1'b1;
    @(negedge clk);
    bypass_flush = 1'b0;
    e_v = 1'b0;
  endtask

  task automatic junk_req();
    req_valid = 1'($urandom_range(0, 1));
    req_type  = 4'($urandom);
    req_addr  = {$urandom, $urandom};
    req_data  = {$urandom, $urandom};
  endtask

  task automatic chk_reset_outs(input string p);
    check({p, "_ready"}, req_ready, 1);
    check({p, "_busy"},  busy,      0);
    check({p, "_rd"},    mem_rd_en, 0);
    check({p, "_wr"},    mem_wr_en, 0);
    check({p, "_addr"},  mem_addr,  0);
    check({p, "_wdata"}, mem_wdata, 0);
    check({p, "_done"},  done,      0);
    check({p, "_err"},   err,       0);
  endtask

  // One store, start to finish. Called at a negedge; returns at the negedge
  // of the cycle after the expected done pulse.
  task automatic do_store(input logic [3:0] t, input logic [63:0] a,
                          input logic [63:0] d, input bit flush_wr,
                          output logic [63:0] wdata_seen);
    int          waited, rd_n, wr_n, dn_n, both_n, stray_err;
    int          rd_c, wr_c, dn_c, e_rd, e_wr, e_dn, nb;
    logic [63:0] rd_a, wr_a, old, m, exp_wd;
    logic        err_seen;
    bit          legal, hit;

    waited = 0;
    while (!req_ready && waited < 40) begin
      junk_req();
      @(negedge clk);
      waited++;
    end
    check("ready_before_req", req_ready, 1);

    // Expected behaviour from the store rules.
    legal = (t <= 4'd3);
    nb    = (t == 4'd0) ? 4 : (t == 4'd1) ? 2 : (t == 4'd2) ? 1 : 8;
    hit   = BYP && e_v && (e_a == a) && (t < 4'd3);
    old   = hit ? e_d : mdl_rd(a);
    if (nb == 8) begin
      exp_wd = d;
    end else begin
      m      = 64'd1 << (8 * nb);
      exp_wd = old - (old % m) + (d % m);
    end
    if (!legal) begin
      e_rd = -1; e_wr = -1; e_dn = 1;
    end else if (t == 4'd3 || hit) begin
      e_rd = -1; e_wr = 1;  e_dn = 2;
    end else begin
      e_rd = 1;  e_wr = 2 + int'(LAT); e_dn = 3 + int'(LAT);
    end

    rd_n = 0; wr_n = 0; dn_n = 0; both_n = 0; stray_err = 0;
    rd_c = -1; wr_c = -1; dn_c = -1;
    rd_a = '0; wr_a = '0; err_seen = 1'b0; wdata_seen = '0;

    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_data  = d;

    for (int cyc = 1; cyc <= e_dn + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check("ready_low_after_accept", req_ready, 0);
        check("busy_after_accept", busy, 1);
        junk_req();
      end
      if (mem_rd_en) begin rd_n++; rd_c = cyc; rd_a = mem_addr; end
      if (mem_wr_en) begin wr_n++; wr_c = cyc; wr_a = mem_addr; wdata_seen = mem_wdata; end
      if (mem_rd_en && mem_wr_en) both_n++;
      if (done) begin dn_n++; dn_c = cyc; err_seen = err; end
      if (err && !done) stray_err++;
      bypass_flush = flush_wr && (cyc == e_wr);
      if (cyc == e_dn + 1) begin
        check("ready_after_done", req_ready, 1);
        check("busy_after_done", busy, 0);
        req_valid = 1'b0;
      end
    end
    bypass_flush = 1'b0;

    check("rd_count", rd_n, (e_rd > 0) ? 1 : 0);
    if (e_rd > 0) begin
      check("rd_cycle", rd_c, e_rd);
      check("rd_addr", rd_a, a);
    end
    check("wr_count", wr_n, legal ? 1 : 0);
    if (legal) begin
      check("wr_cycle", wr_c, e_wr);
      check("wr_addr", wr_a, a);
      check("wr_data", wdata_seen, exp_wd);
    end
    check("done_count", dn_n, 1);
    check("done_cycle", dn_c, e_dn);
    check("err_with_done", err_seen, !legal);
    check("err_stray", stray_err, 0);
    check("rd_wr_overlap", both_n, 0);

    if (legal) begin
      mdl_mem[a] = exp_wd;
      e_v = !flush_wr;
      e_a = a;
      e_d = exp_wd;
    end
  endtask

  // SB whose read is cut short by reset in cycle 3.
  task automatic reset_mid_sb(input logic [63:0] a);
    int wr_seen;
    wr_seen = 0;
    check("ready_before_rst_sb", req_ready, 1);
    req_valid = 1'b1;
    req_type  = 4'd2;
    req_addr  = a;
    req_data  = {$urandom, $urandom};
    @(negedge clk);                  // cycle 1
    req_valid = 1'b0;
    check("rst_sb_rd_strobe", mem_rd_en, 1);
    @(negedge clk);                  // cycle 2
    @(negedge clk);                  // cycle 3
    reset = 1'b0;
    #1;
    chk_reset_outs("midrst");
    e_v = 1'b0;
    for (int i = 0; i < 2 * int'(LAT) + 6; i++) begin
      @(negedge clk);
      if (i == 3) reset = 1'b1;
      if (mem_wr_en) wr_seen++;
      if (done || err) wr_seen++;
    end
    check("midrst_no_write", wr_seen, 0);
    check("midrst_ready", req_ready, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] w;
    logic [63:0] pool [4];
    logic [63:0] a;
    logic [3:0]  t;

    pool[0] = 64'h40;
    pool[1] = 64'h48;
    pool[2] = 64'h1000;
    pool[3] = 64'hFFFF_FFFF_FFFF_FFF8;

    reset        = 1'b0;
    req_valid    = 1'b0;
    req_type     = '0;
    req_addr     = '0;
    req_data     = '0;
    bypass_flush = 1'b0;
    e_v          = 1'b0;
    e_a          = '0;
    e_d          = '0;

    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b1;
    @(negedge clk);

    // SW merge
    poke(64'h100, 64'hAAAA_BBBB_CCCC_DDDD);
    do_store(4'd0, 64'h100, 64'h1111_2222_3333_4444, 1'b0, w);
    check("plan_sw", w, 64'hAAAA_BBBB_3333_4444);

    // SH then SB with memory restored to all ones in between
    poke(64'h200, 64'hFFFF_FFFF_FFFF_FFFF);
    do_store(4'd1, 64'h200, 64'h0123_4567_89AB_CDEF, 1'b0, w);
    check("plan_sh", w, 64'hFFFF_FFFF_FFFF_CDEF);
    poke(64'h200, 64'hFFFF_FFFF_FFFF_FFFF);
    do_store(4'd2, 64'h200, 64'h0123_4567_89AB_CDEF, 1'b0, w);
    check("plan_sb", w, BYP ? 64'hFFFF_FFFF_FFFF_CDEF : 64'hFFFF_FFFF_FFFF_FFEF);

    // SD and illegal type
    do_store(4'd3, 64'h300, 64'hDEAD_BEEF_0000_0001, 1'b0, w);
    check("plan_sd", w, 64'hDEAD_BEEF_0000_0001);
    do_store(4'd5, 64'h308, 64'h5555_5555_5555_5555, 1'b0, w);

    // Reset in the middle of an SB, then a fresh request
    flush_pulse();
    poke(64'h500, 64'h0F0F_0F0F_0F0F_0F0F);
    reset_mid_sb(64'h500);
    do_store(4'd2, 64'h500, 64'h0000_0000_0000_00A5, 1'b0, w);
    check("post_reset_sb", w, 64'h0F0F_0F0F_0F0F_0FA5);

    // Bypass sequences (full reads when the feature is absent)
    do_store(4'd3, 64'h40, 64'h0102_0304_0506_0708, 1'b0, w);
    do_store(4'd0, 64'h40, 64'hFFFF_FFFF_AAAA_BBBB, 1'b0, w);
    do_store(4'd3, 64'h40, 64'h1020_3040_5060_7080, 1'b0, w);
    flush_pulse();
    do_store(4'd0, 64'h40, 64'h9999_9999_CCCC_DDDD, 1'b0, w);
    do_store(4'd3, 64'h40, 64'h1122_3344_5566_7788, 1'b1, w);
    do_store(4'd1, 64'h40, 64'h0000_0000_0000_EEEE, 1'b0, w);

    // Randomised traffic over a small address pool
    for (int k = 0; k < 150; k++) begin
      a = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 99) < 8) t = 4'($urandom_range(4, 15));
      else                           t = 4'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       poke(a, {$urandom, $urandom});
        1:       flush_pulse();
        default: ;
      endcase
      do_store(t, a, {$urandom, $urandom}, $urandom_range(0, 9) == 0, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
